// File: rtl/sba_initiator.sv
// sba_initiator: command-driven SBA bus master issuing single/burst beats with per-beat responses and ack timeout
module sba_initiator #(
  parameter logic [15:0] ADDR_STEP = 16'd4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_cmd_addr,
  input  logic [3:0]  i_cmd_we,
  input  logic [31:0] i_cmd_data,
  input  logic [7:0]  i_cmd_len,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_rsp_last,
  output logic [15:0] o_ext_addr,
  output logic        o_ext_stb,
  output logic [3:0]  o_ext_we,
  input  logic        i_ext_ack,
  output logic [31:0] o_ext_dat_w,
  input  logic [31:0] i_ext_dat_r
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state, state_n;
  logic [15:0] addr;
  logic [3:0]  we;
  logic [31:0] dat;
  logic [7:0]  beat;
  logic [31:0] tcnt;
  logic [31:0] rdata;
  logic        err;
  logic        timeout;
  logic        done;
  assign timeout = (TIMEOUT != 0) && (tcnt == TIMEOUT - 1);
  assign done = err || (beat == 8'd0);
  assign o_cmd_ready = state == IDLE;
  assign o_ext_stb = state == REQ;
  assign o_rsp_valid = state == RSP;
  assign o_rsp_data = rdata;
  assign o_rsp_err = err;
  assign o_rsp_last = (state == RSP) && done;
  assign o_ext_addr = addr;
  assign o_ext_we = we;
  assign o_ext_dat_w = dat;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (i_cmd_valid ? REQ : IDLE)
            : state == REQ  ? ((i_ext_ack || timeout) ? RSP : REQ)
            : (i_rsp_ready ? (done ? IDLE : REQ) : RSP);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr  <= '0;
      we    <= '0;
      dat   <= '0;
      beat  <= '0;
      tcnt  <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (state == IDLE && i_cmd_valid) begin
        addr  <= i_cmd_addr;
        we    <= i_cmd_we;
        dat   <= i_cmd_data;
        beat  <= i_cmd_len;
        tcnt  <= '0;
        rdata <= '0;
        err   <= 1'b0;
      end
      if (state == REQ) begin
        tcnt <= tcnt + 1;
        if (i_ext_ack) rdata <= (we == 4'd0) ? i_ext_dat_r : 32'd0;
        else if (timeout) begin
          err   <= 1'b1;
          rdata <= '0;
        end
      end
      // next beat: advance address with 16-bit wrap, restart timeout window
      if (state == RSP && i_rsp_ready && !done) begin
        addr <= addr + ADDR_STEP;
        beat <= beat - 8'd1;
        tcnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sba_initiator.sv
// tb_sba_initiator: directed checks of sba_initiator against a simple acking slave model
module tb_sba_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic [3:0]  cmd_we = '0;
  logic [31:0] cmd_data = '0;
  logic [7:0]  cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic [15:0] ext_addr;
  logic        ext_stb;
  logic [3:0]  ext_we;
  logic        ext_ack = 1'b0;
  logic [31:0] ext_dat_w;
  logic [31:0] ext_dat_r = 32'hDEADBEEF;
  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  logic ack_en = 1'b1;
  int ack_cnt = 0;
  int stb_cycles = 0;
  int n_log = 0;
  logic [15:0] log_addr [0:15];
  logic [3:0]  log_we [0:15];
  logic [31:0] log_dat [0:15];
  sba_initiator dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_addr(cmd_addr), .i_cmd_we(cmd_we), .i_cmd_data(cmd_data), .i_cmd_len(cmd_len),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_rsp_last(rsp_last),
    .o_ext_addr(ext_addr), .o_ext_stb(ext_stb), .o_ext_we(ext_we),
    .i_ext_ack(ext_ack), .o_ext_dat_w(ext_dat_w), .i_ext_dat_r(ext_dat_r)
  );
  always #5 clk = ~clk;
  // slave: acks ack_delay cycles after seeing strobe, logs each acked access
  always @(negedge clk) begin
    if (ext_stb) stb_cycles = stb_cycles + 1;
    if (ext_stb && ack_en && !ext_ack) begin
      if (ack_cnt == ack_delay) begin
        ext_ack = 1'b1;
        ack_cnt = 0;
        if (n_log < 16) begin
          log_addr[n_log] = ext_addr;
          log_we[n_log] = ext_we;
          log_dat[n_log] = ext_dat_w;
        end
        n_log = n_log + 1;
      end else ack_cnt = ack_cnt + 1;
    end else begin
      ext_ack = 1'b0;
      if (!ext_stb) ack_cnt = 0;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_cmd(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d, input logic [7:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_we = w; cmd_data = d; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 16'hAAAA; cmd_we = 4'hA; cmd_data = 32'h55555555; cmd_len = 8'h77;
  endtask
  task automatic get_rsp(output logic [31:0] d, output logic e, output logic l);
    int n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) check("rsp_wait_timeout", 32'd0, 32'd1);
    d = rsp_data; e = rsp_err; l = rsp_last;
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] d;
    logic e, l;
    logic stb_hi, unstable;
    logic [31:0] hold_d;
    logic hold_l;
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_stb", {31'd0, ext_stb}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
    check("rst_addr", {16'd0, ext_addr}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // single read, ack two cycles after strobe
    ack_delay = 2; n_log = 0;
    send_cmd(16'h0010, 4'h0, 32'h0, 8'd0);
    get_rsp(d, e, l);
    check("rd_data", d, 32'hDEADBEEF);
    check("rd_err", {31'd0, e}, 32'd0);
    check("rd_last", {31'd0, l}, 32'd1);
    check("rd_addr", {16'd0, log_addr[0]}, 32'h0010);
    check("rd_ready_after", {31'd0, cmd_ready}, 32'd1);
    // 4-beat write burst
    ack_delay = 1; n_log = 0;
    send_cmd(16'h0100, 4'b0001, 32'h000000A5, 8'd3);
    for (int i = 0; i < 4; i++) begin
      get_rsp(d, e, l);
      check($sformatf("wr_data%0d", i), d, 32'd0);
      check($sformatf("wr_last%0d", i), {31'd0, l}, (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("wr_addr%0d", i), {16'd0, log_addr[i]}, 32'h0100 + 32'(i * 4));
      check($sformatf("wr_we%0d", i), {28'd0, log_we[i]}, 32'd1);
      check($sformatf("wr_dat%0d", i), log_dat[i], 32'hA5);
    end
    check("wr_beats", n_log, 32'd4);
    check("wr_ready_after", {31'd0, cmd_ready}, 32'd1);
    // no ack: timeout after exactly 255 strobe cycles, remaining beats dropped
    ack_en = 1'b0; stb_cycles = 0; n_log = 0;
    send_cmd(16'h0200, 4'h0, 32'h0, 8'd2);
    get_rsp(d, e, l);
    check("to_err", {31'd0, e}, 32'd1);
    check("to_last", {31'd0, l}, 32'd1);
    check("to_data", d, 32'd0);
    check("to_stb_cycles", stb_cycles, 32'd255);
    check("to_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("to_no_stray_rsp", {31'd0, rsp_valid}, 32'd0);
    // burst wrapping through 0xFFFF
    ack_en = 1'b1; ack_delay = 0; n_log = 0; ext_dat_r = 32'h0BADF00D;
    send_cmd(16'hFFF8, 4'h0, 32'h0, 8'd2);
    for (int i = 0; i < 3; i++) begin
      get_rsp(d, e, l);
      check($sformatf("wrap_data%0d", i), d, 32'h0BADF00D);
      check($sformatf("wrap_last%0d", i), {31'd0, l}, (i == 2) ? 32'd1 : 32'd0);
    end
    check("wrap_addr0", {16'd0, log_addr[0]}, 32'hFFF8);
    check("wrap_addr1", {16'd0, log_addr[1]}, 32'hFFFC);
    check("wrap_addr2", {16'd0, log_addr[2]}, 32'h0000);
    // response back-pressure mid burst
    n_log = 0; rsp_ready = 1'b0;
    send_cmd(16'h0300, 4'hF, 32'h12345678, 8'd1);
    for (int n = 0; n < 200 && !rsp_valid; n++) @(negedge clk);
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    hold_d = rsp_data; hold_l = rsp_last; stb_hi = 1'b0; unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stb_hi |= ext_stb;
      unstable |= (rsp_data !== hold_d) || (rsp_last !== hold_l) || !rsp_valid;
    end
    check("bp_stb_low", {31'd0, stb_hi}, 32'd0);
    check("bp_stable", {31'd0, unstable}, 32'd0);
    check("bp_beats_held", n_log, 32'd1);
    rsp_ready = 1'b1;
    get_rsp(d, e, l);
    check("bp_last0", {31'd0, l}, 32'd0);
    get_rsp(d, e, l);
    check("bp_last1", {31'd0, l}, 32'd1);
    check("bp_addr1", {16'd0, log_addr[1]}, 32'h0304);
    check("bp_dat1", log_dat[1], 32'h12345678);
    // asynchronous reset while strobe is high
    ack_en = 1'b0;
    send_cmd(16'h0400, 4'h0, 32'h0, 8'd0);
    repeat (3) @(negedge clk);
    check("ar_stb_before", {31'd0, ext_stb}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_stb_drop", {31'd0, ext_stb}, 32'd0);
    check("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("ar_ready", {31'd0, cmd_ready}, 32'd1);
    check("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
